bp_be_fe_cmd_gen: RTL and testbench

- Back-end side issuer of the FE-BE command channel (fe_cmd), the BE-to-FE direction of the FE-BE interface.
- Collects redirect, fill and fence requests from BE units (commit, exception, branch resolve, PTW, fence logic).
- Arbitrates them by fixed priority and drives one fe_cmd at a time over valid/ready.
- Pulses a flush to the BE's fe_queue on every redirect and waits for FE acknowledgement of fences.

---
 rtl/bp_be_fe_cmd_pkg.sv | 45 ++++
 rtl/bp_be_fe_cmd_arb.sv | 43 ++++
 rtl/bp_be_fe_cmd_gen.sv | 170 +++++++++++++++++
 tb/tb_bp_be_fe_cmd_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_fe_cmd_pkg.sv
// Shared types for the back-end fe_cmd issuer: opcode enum, FSM state enum,
// a macro that declares the width-parameterised command struct, and small
// opcode classification helpers.

`ifndef BP_FE_CMD_PKG_MACROS_DEFINED
`define BP_FE_CMD_PKG_MACROS_DEFINED
`define BP_FE_CMD_S_DECLARE(vaddr_w, operand_w) \
  typedef struct packed { \
    bp_fe_cmd_opcode_e      opcode; \
    logic [vaddr_w-1:0]     vaddr; \
    logic [operand_w-1:0]   operand; \
  } bp_fe_cmd_s
`endif

package bp_be_fe_cmd_pkg;

  // Opcode value doubles as arbitration priority (0 = highest) and grant bit.
  typedef enum logic [2:0] {
    e_op_state_reset  = 3'd0,
    e_op_pc_redirect  = 3'd1,
    e_op_br_redirect  = 3'd2,
    e_op_itlb_fill    = 3'd3,
    e_op_icache_fence = 3'd4,
    e_op_itlb_fence   = 3'd5
  } bp_fe_cmd_opcode_e;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_send  = 2'd1,
    e_fence = 2'd2
  } bp_fe_cmd_state_e;

  localparam int fe_cmd_src_num = 6;

  // Redirects discard whatever the FE has already queued up for the BE.
  function automatic logic is_redirect(input logic [2:0] op);
    return (op <= 3'd2);
  endfunction

  // Fences need an explicit completion handshake from the FE.
  function automatic logic is_fence(input logic [2:0] op);
    return (op == 3'd4) || (op == 3'd5);
  endfunction

endpackage

// File: rtl/bp_be_fe_cmd_arb.sv
// Fixed-priority 6:1 arbiter for fe_cmd sources. Source index equals opcode;
// lower index wins. Produces a one-hot grant and the winner's payload.

module bp_be_fe_cmd_arb
  import bp_be_fe_cmd_pkg::*;
#(
  parameter int vaddr_width_p   = 39,
  parameter int operand_width_p = 64
) (
  input  logic                                   en_i,
  input  logic [fe_cmd_src_num-1:0]              req_i,
  input  logic [fe_cmd_src_num*vaddr_width_p-1:0]   vaddr_i,
  input  logic [fe_cmd_src_num*operand_width_p-1:0] operand_i,
  output logic [fe_cmd_src_num-1:0]              grant_o,
  output logic                                   v_o,
  output logic [2:0]                             opcode_o,
  output logic [vaddr_width_p-1:0]               vaddr_o,
  output logic [operand_width_p-1:0]             operand_o
);

  // A source wins when it requests and no lower-index source requests.
  for (genvar gi = 0; gi < fe_cmd_src_num; gi++) begin : g_grant
    localparam logic [fe_cmd_src_num-1:0] higher_mask = fe_cmd_src_num'((1 << gi) - 1);
    assign grant_o[gi] = en_i & req_i[gi] & ~|(req_i & higher_mask);
  end

  assign v_o = |grant_o;

  // AND-OR mux of the winner's opcode and payload; all zero when nothing wins.
  always_comb begin
    opcode_o  = '0;
    vaddr_o   = '0;
    operand_o = '0;
    for (int i = 0; i < fe_cmd_src_num; i++) begin
      if (grant_o[i]) begin
        opcode_o  = opcode_o  | 3'(i);
        vaddr_o   = vaddr_o   | vaddr_i[i*vaddr_width_p +: vaddr_width_p];
        operand_o = operand_o | operand_i[i*operand_width_p +: operand_width_p];
      end
    end
  end

endmodule

// File: rtl/bp_be_fe_cmd_gen.sv
// Back-end fe_cmd issuer: arbitrates BE redirect/fill/fence requests, drives
// one fe_cmd at a time over valid/ready, flushes fe_queue on redirects and
// waits (bounded) for FE fence completion.
// Optional macro BP_BE_FE_CMD_STATS_EN adds accepted-command, redirect and
// fence-timeout statistics counters.

module bp_be_fe_cmd_gen
  import bp_be_fe_cmd_pkg::*;
#(
  parameter int vaddr_width_p   = 39,
  parameter int operand_width_p = 64,
  parameter int fence_timeout_p = 255
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       reset_req_v_i,
  input  logic [vaddr_width_p-1:0]   reset_req_pc_i,
  input  logic                       exc_v_i,
  input  logic [vaddr_width_p-1:0]   exc_pc_i,
  input  logic [operand_width_p-1:0] exc_op_i,
  input  logic                       mispred_v_i,
  input  logic [vaddr_width_p-1:0]   mispred_pc_i,
  input  logic [operand_width_p-1:0] mispred_op_i,
  input  logic                       itlb_fill_v_i,
  input  logic [vaddr_width_p-1:0]   itlb_fill_vaddr_i,
  input  logic [operand_width_p-1:0] itlb_fill_op_i,
  input  logic                       icache_fence_v_i,
  input  logic                       itlb_fence_v_i,
  output logic [5:0]                 grant_o,
  output logic                       fe_cmd_v_o,
  input  logic                       fe_cmd_ready_i,
  output logic [2:0]                 fe_cmd_opcode_o,
  output logic [vaddr_width_p-1:0]   fe_cmd_vaddr_o,
  output logic [operand_width_p-1:0] fe_cmd_operand_o,
  output logic                       fe_queue_flush_o,
  input  logic                       fence_done_i,
  output logic                       fence_timeout_o,
`ifdef BP_BE_FE_CMD_STATS_EN
  output logic [31:0]                stat_cmd_cnt_o,
  output logic [31:0]                stat_redirect_cnt_o,
  output logic [15:0]                stat_timeout_cnt_o,
`endif
  output logic                       busy_o
);

  `BP_FE_CMD_S_DECLARE(vaddr_width_p, operand_width_p);

  localparam int cnt_w = $clog2(fence_timeout_p + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(fence_timeout_p - 1);

  bp_fe_cmd_state_e     state_reg;
  bp_fe_cmd_s           cmd_reg;
  logic [cnt_w-1:0]     cnt_reg;
  logic                 timeout_reg;

  logic [5:0]                 arb_req;
  logic                       arb_en;
  logic                       gnt_v;
  logic [2:0]                 gnt_opcode;
  logic [vaddr_width_p-1:0]   gnt_vaddr;
  logic [operand_width_p-1:0] gnt_operand;

  // While a fence is outstanding only a state reset may cut in; everything
  // else waits. Nothing is granted while a command is on the wire or in reset.
  assign arb_req = (state_reg == e_fence)
                 ? {5'b0, reset_req_v_i}
                 : {itlb_fence_v_i, icache_fence_v_i, itlb_fill_v_i,
                    mispred_v_i, exc_v_i, reset_req_v_i};
  assign arb_en  = reset_n_i & (state_reg != e_send);

  bp_be_fe_cmd_arb #(
    .vaddr_width_p   (vaddr_width_p),
    .operand_width_p (operand_width_p)
  ) arb (
    .en_i      (arb_en),
    .req_i     (arb_req),
    .vaddr_i   ({vaddr_width_p'(0), vaddr_width_p'(0), itlb_fill_vaddr_i,
                 mispred_pc_i, exc_pc_i, reset_req_pc_i}),
    .operand_i ({operand_width_p'(0), operand_width_p'(0), itlb_fill_op_i,
                 mispred_op_i, exc_op_i, operand_width_p'(0)}),
    .grant_o   (grant_o),
    .v_o       (gnt_v),
    .opcode_o  (gnt_opcode),
    .vaddr_o   (gnt_vaddr),
    .operand_o (gnt_operand)
  );

  assign fe_queue_flush_o = gnt_v & is_redirect(gnt_opcode);
  assign fe_cmd_v_o       = (state_reg == e_send);
  assign fe_cmd_opcode_o  = cmd_reg.opcode;
  assign fe_cmd_vaddr_o   = cmd_reg.vaddr;
  assign fe_cmd_operand_o = cmd_reg.operand;
  assign fence_timeout_o  = timeout_reg;
  assign busy_o           = (state_reg != e_idle);

  // Issue FSM: capture grant, hold command until accepted, then await fence.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= e_idle;
      cmd_reg     <= '0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        e_idle: begin
          if (gnt_v) begin
            cmd_reg   <= '{opcode: bp_fe_cmd_opcode_e'(gnt_opcode),
                           vaddr: gnt_vaddr, operand: gnt_operand};
            state_reg <= e_send;
          end
        end
        e_send: begin
          if (fe_cmd_ready_i) begin
            if (is_fence(cmd_reg.opcode)) begin
              state_reg <= e_fence;
              cnt_reg   <= '0;
            end else begin
              state_reg <= e_idle;
            end
          end
        end
        e_fence: begin
          if (gnt_v) begin
            // State reset aborts the fence wait.
            cmd_reg   <= '{opcode: bp_fe_cmd_opcode_e'(gnt_opcode),
                           vaddr: gnt_vaddr, operand: gnt_operand};
            state_reg <= e_send;
          end else if (fence_done_i) begin
            state_reg <= e_idle;
          end else if (cnt_reg == cnt_last) begin
            timeout_reg <= 1'b1;
            state_reg   <= e_idle;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= e_idle;
      endcase
    end
  end

`ifdef BP_BE_FE_CMD_STATS_EN
  logic [31:0] stat_cmd_reg;
  logic [31:0] stat_redirect_reg;
  logic [15:0] stat_timeout_reg;

  // Free-running wrap-around counters of accepted commands and timeouts.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stat_cmd_reg      <= '0;
      stat_redirect_reg <= '0;
      stat_timeout_reg  <= '0;
    end else begin
      if (fe_cmd_v_o && fe_cmd_ready_i) begin
        stat_cmd_reg <= stat_cmd_reg + 32'd1;
        if (is_redirect(cmd_reg.opcode))
          stat_redirect_reg <= stat_redirect_reg + 32'd1;
      end
      if ((state_reg == e_fence) && !gnt_v && !fence_done_i && (cnt_reg == cnt_last))
        stat_timeout_reg <= stat_timeout_reg + 16'd1;
    end
  end

  assign stat_cmd_cnt_o      = stat_cmd_reg;
  assign stat_redirect_cnt_o = stat_redirect_reg;
  assign stat_timeout_cnt_o  = stat_timeout_reg;
`endif

endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// Self-checking bench for bp_be_fe_cmd_gen: directed request sequences,
// scoreboard of expected fe_cmd transfers popped on each accepted command.

module tb_bp_be_fe_cmd_gen;

  localparam int VW = 39;
  localparam int OW = 64;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          reset_req_v = 1'b0;
  logic [VW-1:0] reset_req_pc = '0;
  logic          exc_v = 1'b0;
  logic [VW-1:0] exc_pc = '0;
  logic [OW-1:0] exc_op = '0;
  logic          mispred_v = 1'b0;
  logic [VW-1:0] mispred_pc = '0;
  logic [OW-1:0] mispred_op = '0;
  logic          itlb_fill_v = 1'b0;
  logic [VW-1:0] itlb_fill_vaddr = '0;
  logic [OW-1:0] itlb_fill_op = '0;
  logic          icache_fence_v = 1'b0;
  logic          itlb_fence_v = 1'b0;
  logic          fe_cmd_ready = 1'b0;
  logic          fence_done = 1'b0;

  logic [5:0]    grant;
  logic          fe_cmd_v;
  logic [2:0]    fe_cmd_opcode;
  logic [VW-1:0] fe_cmd_vaddr;
  logic [OW-1:0] fe_cmd_operand;
  logic          fe_queue_flush;
  logic          fence_timeout;
  logic          busy;
`ifdef BP_BE_FE_CMD_STATS_EN
  logic [31:0]   stat_cmd_cnt;
  logic [31:0]   stat_redirect_cnt;
  logic [15:0]   stat_timeout_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [3+VW+OW-1:0] exp_q[$];
  logic [3+VW+OW-1:0] mon_exp;

  always #5 clk = ~clk;

  bp_be_fe_cmd_gen #(
    .vaddr_width_p   (VW),
    .operand_width_p (OW),
    .fence_timeout_p (TO)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .reset_req_v_i     (reset_req_v),
    .reset_req_pc_i    (reset_req_pc),
    .exc_v_i           (exc_v),
    .exc_pc_i          (exc_pc),
    .exc_op_i          (exc_op),
    .mispred_v_i       (mispred_v),
    .mispred_pc_i      (mispred_pc),
    .mispred_op_i      (mispred_op),
    .itlb_fill_v_i     (itlb_fill_v),
    .itlb_fill_vaddr_i (itlb_fill_vaddr),
    .itlb_fill_op_i    (itlb_fill_op),
    .icache_fence_v_i  (icache_fence_v),
    .itlb_fence_v_i    (itlb_fence_v),
    .grant_o           (grant),
    .fe_cmd_v_o        (fe_cmd_v),
    .fe_cmd_ready_i    (fe_cmd_ready),
    .fe_cmd_opcode_o   (fe_cmd_opcode),
    .fe_cmd_vaddr_o    (fe_cmd_vaddr),
    .fe_cmd_operand_o  (fe_cmd_operand),
    .fe_queue_flush_o  (fe_queue_flush),
    .fence_done_i      (fence_done),
    .fence_timeout_o   (fence_timeout),
`ifdef BP_BE_FE_CMD_STATS_EN
    .stat_cmd_cnt_o      (stat_cmd_cnt),
    .stat_redirect_cnt_o (stat_redirect_cnt),
    .stat_timeout_cnt_o  (stat_timeout_cnt),
`endif
    .busy_o            (busy)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic [2:0] op, input logic [VW-1:0] va, input logic [OW-1:0] opnd);
    exp_q.push_back({op, va, opnd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted command must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && fe_cmd_v && fe_cmd_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_cmd", 128'd1, 128'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_val("fe_cmd", {fe_cmd_opcode, fe_cmd_vaddr, fe_cmd_operand}, mon_exp);
        $display("cmd accepted: op=%0d vaddr=%0h operand=%0h", fe_cmd_opcode, fe_cmd_vaddr, fe_cmd_operand);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, with a request held high to show grant is gated.
    exc_v = 1'b1;
    tick();
    #1;
    check_val("reset_outputs", {grant, fe_cmd_v, fe_cmd_opcode, fe_queue_flush, fence_timeout, busy}, '0);
    check_val("reset_payload", {fe_cmd_vaddr, fe_cmd_operand}, '0);
    exc_v = 1'b0;
    tick();
    reset_n = 1'b1;

    // Reset in the middle of SEND.
    tick();
    itlb_fill_v = 1'b1; itlb_fill_vaddr = 39'h1000; itlb_fill_op = 64'h55;
    #1;
    check_val("pre_rst_grant", grant, 6'b001000);
    tick();
    itlb_fill_v = 1'b0;
    #1;
    check_val("pre_rst_send", {fe_cmd_v, fe_cmd_opcode}, {1'b1, 3'd3});
    reset_n = 1'b0;
    tick();
    check_val("midsend_rst_outputs", {grant, fe_cmd_v, fe_cmd_opcode, fe_queue_flush, fence_timeout, busy}, '0);
    check_val("midsend_rst_payload", {fe_cmd_vaddr, fe_cmd_operand}, '0);
    reset_n = 1'b1;
    tick();
    check_val("post_rst_idle", busy, 1'b0);

    // Exception beats mispredict; mispredict follows two cycles later.
    fe_cmd_ready = 1'b1;
    exc_v = 1'b1; exc_pc = 39'h80000100; exc_op = 64'hA1;
    mispred_v = 1'b1; mispred_pc = 39'h80000200; mispred_op = 64'hB2;
    #1;
    check_val("exc_grant", grant, 6'b000010);
    check_val("exc_flush", fe_queue_flush, 1'b1);
    push_exp(3'd1, 39'h80000100, 64'hA1);
    tick();
    exc_v = 1'b0;
    #1;
    check_val("exc_send", {fe_cmd_v, fe_cmd_opcode, fe_cmd_vaddr}, {1'b1, 3'd1, 39'h80000100});
    check_val("send_no_grant", grant, 6'b0);
    tick();
    check_val("mispred_grant", grant, 6'b000100);
    check_val("mispred_flush", fe_queue_flush, 1'b1);
    push_exp(3'd2, 39'h80000200, 64'hB2);
    tick();
    mispred_v = 1'b0;
    tick();
    check_val("idle_after_mispred", busy, 1'b0);

    // Backpressure: payload stable, no grant while a second fill waits.
    fe_cmd_ready = 1'b0;
    itlb_fill_v = 1'b1; itlb_fill_vaddr = 39'h2000; itlb_fill_op = 64'hC3;
    #1;
    check_val("fill_grant", grant, 6'b001000);
    check_val("fill_no_flush", fe_queue_flush, 1'b0);
    push_exp(3'd3, 39'h2000, 64'hC3);
    tick();
    itlb_fill_vaddr = 39'h3000; itlb_fill_op = 64'hD4;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val("stall_payload", {fe_cmd_v, fe_cmd_opcode, fe_cmd_vaddr, fe_cmd_operand}, {1'b1, 3'd3, 39'h2000, 64'hC3});
      check_val("stall_grant", grant, 6'b0);
      tick();
    end
    fe_cmd_ready = 1'b1;
    tick();
    check_val("fill2_grant", grant, 6'b001000);
    push_exp(3'd3, 39'h3000, 64'hD4);
    tick();
    itlb_fill_v = 1'b0;
    tick();

    // Icache fence completed by FE on the third FENCE cycle.
    icache_fence_v = 1'b1;
    #1;
    check_val("icf_grant", grant, 6'b010000);
    push_exp(3'd4, '0, '0);
    tick();
    icache_fence_v = 1'b0;
    tick();
    check_val("fence_cyc1", {fe_cmd_v, busy}, 2'b01);
    tick();
    tick();
    fence_done = 1'b1;
    tick();
    fence_done = 1'b0;
    check_val("fence_done_idle", {busy, fence_timeout}, 2'b00);

    // ITLB fence with no done: timeout pulse after exactly TO cycles.
    itlb_fence_v = 1'b1;
    #1;
    check_val("itf_grant", grant, 6'b100000);
    push_exp(3'd5, '0, '0);
    tick();
    itlb_fence_v = 1'b0;
    for (int i = 0; i < TO; i++) begin
      tick();
      check_val("fence_wait", {busy, fence_timeout}, 2'b10);
    end
    tick();
    check_val("timeout_pulse", {busy, fence_timeout}, 2'b01);
    tick();
    check_val("timeout_one_cycle", fence_timeout, 1'b0);

    // State reset aborts a fence; the pending fill waits until afterward.
    icache_fence_v = 1'b1;
    push_exp(3'd4, '0, '0);
    tick();
    icache_fence_v = 1'b0;
    tick();
    reset_req_v = 1'b1; reset_req_pc = '0;
    itlb_fill_v = 1'b1; itlb_fill_vaddr = 39'h4000; itlb_fill_op = 64'hE5;
    #1;
    check_val("abort_grant", grant, 6'b000001);
    check_val("abort_flush", fe_queue_flush, 1'b1);
    push_exp(3'd0, '0, '0);
    tick();
    reset_req_v = 1'b0;
    check_val("abort_send", {fe_cmd_v, fe_cmd_opcode}, {1'b1, 3'd0});
    tick();
    check_val("fill3_grant", grant, 6'b001000);
    push_exp(3'd3, 39'h4000, 64'hE5);
    tick();
    itlb_fill_v = 1'b0;
    tick();

    // Done on the same cycle the counter expires: done wins, no pulse.
    itlb_fence_v = 1'b1;
    push_exp(3'd5, '0, '0);
    tick();
    itlb_fence_v = 1'b0;
    for (int i = 0; i < TO - 1; i++) tick();
    tick();
    fence_done = 1'b1;
    tick();
    fence_done = 1'b0;
    check_val("done_beats_timeout", {busy, fence_timeout}, 2'b00);
    tick();
    check_val("done_beats_timeout_late", fence_timeout, 1'b0);
`ifdef BP_BE_FE_CMD_STATS_EN
    check_val("stat_timeout", stat_timeout_cnt, 16'd1);
    check_val("stat_cmd", stat_cmd_cnt, 32'd10);
    check_val("stat_redirect", stat_redirect_cnt, 32'd3);
`endif

    check_val("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
